// File: rtl/mc_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// mc_axi_mem_slave
// AXI3 slave memory model sitting at the memory-controller end of the cache
// fetch (AR/R) and write-back (AW/W/B) interfaces. It serves INCR bursts from
// an internal array of 2^MEM_AW 32-bit words. Read and write channels are
// independent state machines that run concurrently.
//
// Optional build macro: MC_RLAT_EN
//   defined   : first R beat appears RD_LAT cycles after AR acceptance
//   undefined : first R beat appears 1 cycle after AR acceptance (RD_LAT unused)
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   cm_ar* / cm_arready           read address channel (id, addr, len, burst)
//   mc_r*  / mc_rready            read data channel (data, id, resp, last)
//   cm_aw* / cm_awready           write address channel
//   cm_w*  / cm_wready            write data channel (data, strobes, last)
//   mc_b*  / mc_bready            write response channel (id, resp)
// Responses: 2'b00 OKAY, 2'b10 SLVERR (bad burst type, misaligned or
// out-of-range address, or W beat count not matching awlen).
// -----------------------------------------------------------------------------
module mc_axi_mem_slave #(
  parameter int         MEM_AW     = 12,
  parameter int         RD_LAT     = 4,
  parameter logic [1:0] BURST_INCR = 2'b01
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cm_arvalid,
  output logic        cm_arready,
  input  logic [5:0]  cm_arid,
  input  logic [31:0] cm_araddr,
  input  logic [3:0]  cm_arlen,
  input  logic [1:0]  cm_arburst,
  output logic        mc_rvalid,
  input  logic        mc_rready,
  output logic [31:0] mc_rdata,
  output logic [5:0]  mc_rid,
  output logic [1:0]  mc_rresp,
  output logic        mc_rlast,
  input  logic        cm_awvalid,
  output logic        cm_awready,
  input  logic [5:0]  cm_awid,
  input  logic [31:0] cm_awaddr,
  input  logic [3:0]  cm_awlen,
  input  logic [1:0]  cm_awburst,
  input  logic        cm_wvalid,
  output logic        cm_wready,
  input  logic [31:0] cm_wdata,
  input  logic [3:0]  cm_wstrb,
  input  logic        cm_wlast,
  output logic        mc_bvalid,
  input  logic        mc_bready,
  output logic [5:0]  mc_bid,
  output logic [1:0]  mc_bresp
);

`ifdef MC_RLAT_EN
  localparam int LAT_EXTRA = (RD_LAT > 1) ? RD_LAT - 1 : 0;
`else
  // Fixed one-cycle latency: RD_LAT has no effect in this build.
  localparam int LAT_EXTRA = 0 * RD_LAT;
`endif

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_ADDR = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

  // Burst is decided erroneous once, when its address is accepted.
  function automatic logic addr_err(input logic [31:0] addr, input logic [1:0] burst);
    addr_err = (burst != BURST_INCR) || (addr[1:0] != 2'b00) ||
               ((addr >> (MEM_AW + 2)) != 32'd0);
  endfunction

  logic [31:0] mem_r [2**MEM_AW];

  r_state_t          r_state_r, r_state_s;
  logic              arready_r, arready_s;
  logic              rvalid_r, rvalid_s;
  logic [31:0]       rdata_r, rdata_s;
  logic [5:0]        rid_r, rid_s;
  logic [1:0]        rresp_r, rresp_s;
  logic              rlast_r, rlast_s;
  logic [MEM_AW-1:0] raddr_r, raddr_s;     // next word to fetch
  logic [3:0]        rcnt_r, rcnt_s;       // beats left after the presented one
  logic              rerr_r, rerr_s;
  logic [7:0]        rwait_r, rwait_s;
  logic              fetch_s, fetch_err_s;
  logic [MEM_AW-1:0] fetch_addr_s;
  logic [3:0]        fetch_cnt_s;

  w_state_t          w_state_r, w_state_s;
  logic              awready_r, awready_s;
  logic              wready_r, wready_s;
  logic              bvalid_r, bvalid_s;
  logic [5:0]        bid_r, bid_s;
  logic [1:0]        bresp_r, bresp_s;
  logic [MEM_AW-1:0] waddr_r, waddr_s;
  logic [3:0]        wlen_r, wlen_s;
  logic [3:0]        wbeat_r, wbeat_s;
  logic              werr_r, werr_s;
  logic              wmis_r, wmis_s;       // length mismatch already seen
  logic              mis_now_s;
  logic              mem_we_s;

  // Read channel: next state, next registered outputs and beat fetch.
  always_comb begin
    r_state_s    = r_state_r;
    arready_s    = arready_r;
    rvalid_s     = rvalid_r;
    rdata_s      = rdata_r;
    rid_s        = rid_r;
    rresp_s      = rresp_r;
    rlast_s      = rlast_r;
    raddr_s      = raddr_r;
    rcnt_s       = rcnt_r;
    rerr_s       = rerr_r;
    rwait_s      = rwait_r;
    fetch_s      = 1'b0;
    fetch_addr_s = raddr_r;
    fetch_cnt_s  = rcnt_r;
    fetch_err_s  = rerr_r;
    case (r_state_r)
      R_IDLE: begin
        if (cm_arvalid) begin
          arready_s = 1'b0;
          rid_s     = cm_arid;
          rerr_s    = addr_err(cm_araddr, cm_arburst);
          rcnt_s    = cm_arlen;
          raddr_s   = cm_araddr[MEM_AW+1:2];
          if (LAT_EXTRA > 0) begin
            r_state_s = R_WAIT;
            rwait_s   = 8'(LAT_EXTRA - 1);
          end else begin
            fetch_s      = 1'b1;
            fetch_addr_s = cm_araddr[MEM_AW+1:2];
            fetch_cnt_s  = cm_arlen;
            fetch_err_s  = addr_err(cm_araddr, cm_arburst);
          end
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rwait_r == 8'd0) begin
          fetch_s = 1'b1;
        end else begin
          rwait_s = rwait_r - 8'd1;
        end
      end
      R_DATA: begin
        if (mc_rready) begin
          if (rlast_r) begin
            r_state_s = R_IDLE;
            rvalid_s  = 1'b0;
            arready_s = 1'b1;
          end else begin
            fetch_s     = 1'b1;
            fetch_cnt_s = rcnt_r - 4'd1;
          end
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: begin
        r_state_s = R_IDLE;
        rvalid_s  = 1'b0;
        arready_s = 1'b1;
      end
    endcase
    // Array read happens before any same-edge write, so a colliding write
    // is not visible to this beat.
    if (fetch_s) begin
      r_state_s = R_DATA;
      rvalid_s  = 1'b1;
      rdata_s   = fetch_err_s ? 32'd0 : mem_r[fetch_addr_s];
      rresp_s   = fetch_err_s ? 2'b10 : 2'b00;
      rlast_s   = (fetch_cnt_s == 4'd0);
      rcnt_s    = fetch_cnt_s;
      raddr_s   = fetch_addr_s + MEM_AW'(1'b1);
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Read channel state and registered AR/R outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rid_r     <= 6'd0;
      rresp_r   <= 2'b00;
      rlast_r   <= 1'b0;
      raddr_r   <= {MEM_AW{1'b0}};
      rcnt_r    <= 4'd0;
      rerr_r    <= 1'b0;
      rwait_r   <= 8'd0;
    end else begin
      r_state_r <= r_state_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
      rdata_r   <= rdata_s;
      rid_r     <= rid_s;
      rresp_r   <= rresp_s;
      rlast_r   <= rlast_s;
      raddr_r   <= raddr_s;
      rcnt_r    <= rcnt_s;
      rerr_r    <= rerr_s;
      rwait_r   <= rwait_s;
    end
  end

  // Write channel: next state, array write enable and response.
  always_comb begin
    w_state_s = w_state_r;
    awready_s = awready_r;
    wready_s  = wready_r;
    bvalid_s  = bvalid_r;
    bid_s     = bid_r;
    bresp_s   = bresp_r;
    waddr_s   = waddr_r;
    wlen_s    = wlen_r;
    wbeat_s   = wbeat_r;
    werr_s    = werr_r;
    wmis_s    = wmis_r;
    mis_now_s = 1'b0;
    mem_we_s  = 1'b0;
    case (w_state_r)
      W_ADDR: begin
        if (cm_awvalid) begin
          w_state_s = W_DATA;
          awready_s = 1'b0;
          wready_s  = 1'b1;
          bid_s     = cm_awid;
          waddr_s   = cm_awaddr[MEM_AW+1:2];
          wlen_s    = cm_awlen;
          werr_s    = addr_err(cm_awaddr, cm_awburst);
          wbeat_s   = 4'd0;
          wmis_s    = 1'b0;
        end else begin
          w_state_s = W_ADDR;
        end
      end
      W_DATA: begin
        if (cm_wvalid) begin
          // Mismatch: wlast early, or final awlen beat without wlast.
          mis_now_s = (cm_wlast != (wbeat_r == wlen_r));
          mem_we_s  = !werr_r && !wmis_r;
          waddr_s   = waddr_r + MEM_AW'(1'b1);
          wbeat_s   = wbeat_r + 4'd1;
          wmis_s    = wmis_r | mis_now_s;
          if (cm_wlast) begin
            w_state_s = W_RESP;
            wready_s  = 1'b0;
            bvalid_s  = 1'b1;
            bresp_s   = (werr_r || wmis_r || mis_now_s) ? 2'b10 : 2'b00;
          end else begin
            w_state_s = W_DATA;
          end
        end else begin
          w_state_s = W_DATA;
        end
      end
      W_RESP: begin
        if (mc_bready) begin
          w_state_s = W_ADDR;
          bvalid_s  = 1'b0;
          awready_s = 1'b1;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: begin
        w_state_s = W_ADDR;
        awready_s = 1'b1;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
      end
    endcase
  end

  // Write channel state and registered AW/W/B outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_r <= W_ADDR;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= 6'd0;
      bresp_r   <= 2'b00;
      waddr_r   <= {MEM_AW{1'b0}};
      wlen_r    <= 4'd0;
      wbeat_r   <= 4'd0;
      werr_r    <= 1'b0;
      wmis_r    <= 1'b0;
    end else begin
      w_state_r <= w_state_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      bid_r     <= bid_s;
      bresp_r   <= bresp_s;
      waddr_r   <= waddr_s;
      wlen_r    <= wlen_s;
      wbeat_r   <= wbeat_s;
      werr_r    <= werr_s;
      wmis_r    <= wmis_s;
    end
  end

  // Byte-strobed array write; contents are deliberately not reset.
  always_ff @(posedge aclk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (cm_wstrb[i]) begin
          mem_r[waddr_r][8*i +: 8] <= cm_wdata[8*i +: 8];
        end
      end
    end
  end

  assign cm_arready = arready_r;
  assign mc_rvalid  = rvalid_r;
  assign mc_rdata   = rdata_r;
  assign mc_rid     = rid_r;
  assign mc_rresp   = rresp_r;
  assign mc_rlast   = rlast_r;
  assign cm_awready = awready_r;
  assign cm_wready  = wready_r;
  assign mc_bvalid  = bvalid_r;
  assign mc_bid     = bid_r;
  assign mc_bresp   = bresp_r;

endmodule

// File: tb/tb_mc_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_mc_axi_mem_slave
// Self-checking bench for mc_axi_mem_slave. A word-array reference model is
// updated from the burst rules (error bursts write nothing, a burst writes
// min(beats sent, awlen+1) beats) and every R/B output is compared with it.
// -----------------------------------------------------------------------------
module tb_mc_axi_mem_slave;

  localparam int DEPTH = 4096;
`ifdef MC_RLAT_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        aclk, aresetn;
  logic        cm_arvalid, cm_arready;
  logic [5:0]  cm_arid;
  logic [31:0] cm_araddr;
  logic [3:0]  cm_arlen;
  logic [1:0]  cm_arburst;
  logic        mc_rvalid, mc_rready;
  logic [31:0] mc_rdata;
  logic [5:0]  mc_rid;
  logic [1:0]  mc_rresp;
  logic        mc_rlast;
  logic        cm_awvalid, cm_awready;
  logic [5:0]  cm_awid;
  logic [31:0] cm_awaddr;
  logic [3:0]  cm_awlen;
  logic [1:0]  cm_awburst;
  logic        cm_wvalid, cm_wready;
  logic [31:0] cm_wdata;
  logic [3:0]  cm_wstrb;
  logic        cm_wlast;
  logic        mc_bvalid, mc_bready;
  logic [5:0]  mc_bid;
  logic [1:0]  mc_bresp;

  mc_axi_mem_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .cm_arvalid(cm_arvalid), .cm_arready(cm_arready), .cm_arid(cm_arid),
    .cm_araddr(cm_araddr), .cm_arlen(cm_arlen), .cm_arburst(cm_arburst),
    .mc_rvalid(mc_rvalid), .mc_rready(mc_rready), .mc_rdata(mc_rdata),
    .mc_rid(mc_rid), .mc_rresp(mc_rresp), .mc_rlast(mc_rlast),
    .cm_awvalid(cm_awvalid), .cm_awready(cm_awready), .cm_awid(cm_awid),
    .cm_awaddr(cm_awaddr), .cm_awlen(cm_awlen), .cm_awburst(cm_awburst),
    .cm_wvalid(cm_wvalid), .cm_wready(cm_wready), .cm_wdata(cm_wdata),
    .cm_wstrb(cm_wstrb), .cm_wlast(cm_wlast),
    .mc_bvalid(mc_bvalid), .mc_bready(mc_bready), .mc_bid(mc_bid),
    .mc_bresp(mc_bresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] ref_mem [DEPTH];
  logic        bp_on;
  logic [31:0] last_rdata;
  logic [1:0]  last_bresp;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic model_err(input logic [31:0] addr, input logic [1:0] burst);
    return (burst != 2'b01) || (addr % 32'd4 != 32'd0) || (addr >= 32'h0000_4000);
  endfunction

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [5:0] id, input logic [1:0] burst, input int nbeats);
    int guard;
    logic hs, err, done;
    int nwr;
    logic [11:0] w;
    logic [1:0] exp_resp;
    err      = model_err(addr, burst);
    exp_resp = (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    cm_awvalid = 1'b1; cm_awaddr = addr; cm_awlen = len; cm_awid = id; cm_awburst = burst;
    guard = 0;
    do begin hs = cm_awready; tick; guard++; end while (!hs && guard < 100);
    cm_awvalid = 1'b0;
    if (!hs) begin chk("aw_timeout", 32'd0, 32'd1); return; end
    for (int b = 0; b < nbeats; b++) begin
      while (bp_on && $urandom_range(0, 3) == 0) begin cm_wvalid = 1'b0; tick; end
      cm_wvalid = 1'b1; cm_wdata = wd[b]; cm_wstrb = ws[b]; cm_wlast = (b == nbeats - 1);
      guard = 0;
      do begin hs = cm_wready; tick; guard++; end while (!hs && guard < 100);
      if (!hs) begin
        cm_wvalid = 1'b0; cm_wlast = 1'b0;
        chk("w_timeout", 32'd0, 32'd1);
        return;
      end
    end
    cm_wvalid = 1'b0; cm_wlast = 1'b0;
    nwr = err ? 0 : ((nbeats < int'(len) + 1) ? nbeats : int'(len) + 1);
    for (int i = 0; i < nwr; i++) begin
      w = 12'((addr >> 2) + 32'(i));
      for (int k = 0; k < 4; k++)
        if (ws[i][k]) ref_mem[w][8*k +: 8] = wd[i][8*k +: 8];
    end
    guard = 0; done = 1'b0;
    while (!done && guard < 200) begin
      mc_bready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mc_bvalid) begin
        chk("bid", 32'(mc_bid), 32'(id));
        chk("bresp", 32'(mc_bresp), 32'(exp_resp));
        if (mc_bready) begin done = 1'b1; last_bresp = mc_bresp; end
      end
      tick; guard++;
      if (!done && guard > 1 && mc_bvalid == 1'b0 && last_bresp === 2'bxx) last_bresp = 2'b11;
    end
    mc_bready = 1'b0;
    if (!done) chk("b_timeout", 32'd0, 32'd1);
    chk("b_done_bvalid", 32'(mc_bvalid), 32'd0);
    chk("b_done_awready", 32'(cm_awready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [5:0] id, input logic [1:0] burst);
    int guard, beat, lat;
    logic hs, err;
    logic [31:0] exp;
    err = model_err(addr, burst);
    cm_arvalid = 1'b1; cm_araddr = addr; cm_arlen = len; cm_arid = id; cm_arburst = burst;
    guard = 0;
    do begin hs = cm_arready; tick; guard++; end while (!hs && guard < 100);
    cm_arvalid = 1'b0;
    if (!hs) begin chk("ar_timeout", 32'd0, 32'd1); return; end
    beat = 0; lat = 1; guard = 0;
    while (beat <= int'(len) && guard < 400) begin
      mc_rready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("arready_busy", 32'(cm_arready), 32'd0);
      if (mc_rvalid) begin
        if (beat == 0 && lat > 0) begin
          chk("r_latency", 32'(lat), 32'(EXP_LAT));
          lat = 0;
        end
        exp = err ? 32'd0 : ref_mem[12'((addr >> 2) + 32'(beat))];
        chk("rdata", mc_rdata, exp);
        chk("rresp", 32'(mc_rresp), err ? 32'd2 : 32'd0);
        chk("rlast", 32'(mc_rlast), (beat == int'(len)) ? 32'd1 : 32'd0);
        chk("rid", 32'(mc_rid), 32'(id));
        if (mc_rready) begin beat++; last_rdata = mc_rdata; end
      end else if (beat == 0 && lat > 0) begin
        lat++;
      end else begin
        chk("rvalid_gap", 32'd0, 32'd1);
      end
      tick; guard++;
    end
    mc_rready = 1'b0;
    if (beat <= int'(len)) chk("r_timeout", 32'd0, 32'd1);
    chk("r_done_rvalid", 32'(mc_rvalid), 32'd0);
    chk("r_done_arready", 32'(cm_arready), 32'd1);
  endtask

  initial begin
    logic [3:0] len;
    logic [31:0] addr;
    logic [1:0] burst;
    int nb, guard;
    logic hs;
    aresetn = 1'b0; bp_on = 1'b0; last_rdata = 32'd0; last_bresp = 2'b00;
    cm_arvalid = 1'b0; cm_arid = 6'd0; cm_araddr = 32'd0; cm_arlen = 4'd0; cm_arburst = 2'b01;
    mc_rready = 1'b0; mc_bready = 1'b0;
    cm_awvalid = 1'b0; cm_awid = 6'd0; cm_awaddr = 32'd0; cm_awlen = 4'd0; cm_awburst = 2'b01;
    cm_wvalid = 1'b0; cm_wdata = 32'd0; cm_wstrb = 4'd0; cm_wlast = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    tick; tick;
    chk("rst_arready", 32'(cm_arready), 32'd1);
    aresetn = 1'b1;
    tick;
    chk("rst_arready_run", 32'(cm_arready), 32'd1);
    chk("rst_awready", 32'(cm_awready), 32'd1);
    chk("rst_wready", 32'(cm_wready), 32'd0);
    chk("rst_rvalid", 32'(mc_rvalid), 32'd0);
    chk("rst_bvalid", 32'(mc_bvalid), 32'd0);
    chk("rst_rdata", mc_rdata, 32'd0);
    chk("rst_rid", 32'(mc_rid), 32'd0);
    chk("rst_rresp", 32'(mc_rresp), 32'd0);
    chk("rst_rlast", 32'(mc_rlast), 32'd0);
    chk("rst_bid", 32'(mc_bid), 32'd0);
    chk("rst_bresp", 32'(mc_bresp), 32'd0);

    // Initialise words 0..95; words 0x10..0x1F hold 0xA0+i.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = (blk == 1) ? 32'h000000A0 + 32'(i) : $urandom;
        ws[i] = 4'hF;
      end
      axi_write(32'(blk * 64), 4'd15, 6'd1, 2'b01, 16);
    end

    axi_read(32'h40, 4'd15, 6'd5, 2'b01);
    chk("preload_last", last_rdata, 32'h000000AF);

    bp_on = 1'b1;
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h100 + 32'(i); ws[i] = 4'hF; end
    axi_write(32'h80, 4'd15, 6'd5, 2'b01, 16);
    chk("burst_bresp", 32'(last_bresp), 32'd0);
    axi_read(32'h80, 4'd15, 6'd7, 2'b01);
    chk("burst_readback", last_rdata, 32'h0000010F);

    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_write(32'hC0, 4'd0, 6'd2, 2'b01, 1);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    axi_write(32'hC0, 4'd0, 6'd3, 2'b01, 1);
    axi_read(32'hC0, 4'd0, 6'd4, 2'b01);
    chk("strobe_merge", last_rdata, 32'hFF22FF44);

    axi_read(32'h8000_0000, 4'd3, 6'd9, 2'b01);
    chk("oor_rdata", last_rdata, 32'd0);
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(32'h20, 4'd3, 6'd10, 2'b10, 4);
    chk("fixed_burst_bresp", 32'(last_bresp), 32'd2);
    axi_read(32'h20, 4'd3, 6'd11, 2'b01);
    axi_write(32'h30, 4'd3, 6'd12, 2'b01, 3);
    chk("early_wlast_bresp", 32'(last_bresp), 32'd2);
    axi_write(32'h140, 4'd3, 6'd13, 2'b01, 6);
    chk("late_wlast_bresp", 32'(last_bresp), 32'd2);
    axi_read(32'h140, 4'd5, 6'd14, 2'b01);
    axi_write(32'h3FFC, 4'd1, 6'd15, 2'b01, 2);
    axi_read(32'h3FFC, 4'd1, 6'd16, 2'b01);
    axi_read(32'h42, 4'd0, 6'd17, 2'b01);

    // Concurrent read and write on disjoint regions.
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
    fork
      axi_read(32'h0, 4'd15, 6'd20, 2'b01);
      axi_write(32'h100, 4'd15, 6'd21, 2'b01, 16);
    join
    axi_read(32'h100, 4'd15, 6'd22, 2'b01);

    for (int it = 0; it < 40; it++) begin
      len   = 4'($urandom_range(0, 15));
      addr  = 32'($urandom_range(0, 63)) * 32'd4;
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        axi_read(addr, len, 6'($urandom_range(0, 63)), burst);
      end else begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 16)) : int'(len) + 1;
        axi_write(addr, len, 6'($urandom_range(0, 63)), burst, nb);
      end
    end

    // Reset in the middle of a read burst.
    cm_arvalid = 1'b1; cm_araddr = 32'h40; cm_arlen = 4'd15; cm_arid = 6'd3; cm_arburst = 2'b01;
    guard = 0;
    do begin hs = cm_arready; tick; guard++; end while (!hs && guard < 100);
    cm_arvalid = 1'b0;
    mc_rready = 1'b1;
    tick; tick; tick;
    chk("midburst_rvalid_pre", 32'(mc_rvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(mc_rvalid), 32'd0);
    chk("midrst_arready", 32'(cm_arready), 32'd1);
    chk("midrst_rlast", 32'(mc_rlast), 32'd0);
    mc_rready = 1'b0;
    tick; tick;
    aresetn = 1'b1;
    tick;
    chk("postrst_rvalid", 32'(mc_rvalid), 32'd0);
    axi_read(32'h40, 4'd15, 6'd6, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
